// File: rtl/costas_nco_pkg.sv
// Shared parameters and helpers for the Costas-loop NCO: default widths, carrier base,
// clamp limits, dither LFSR constants and the quarter-wave table generator.
package costas_nco_pkg;

  localparam int          DEF_PHASE_W   = 32;
  localparam int          DEF_LUT_AW    = 10;
  localparam int          DEF_OUT_W     = 12;
  localparam logic [31:0] DEF_FREQ_BASE = 32'h4000_0000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 (taps on bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic signed [33:0] CLAMP_HI = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] CLAMP_LO = 34'sh3_8000_0000;
  localparam logic [31:0]        SAT_HI   = 32'h7FFF_FFFF;
  localparam logic [31:0]        SAT_LO   = 32'h8000_0000;

  function automatic logic [31:0] clamp_df(input logic signed [33:0] df);
    logic [31:0] r;
    if (df > CLAMP_HI) r = SAT_HI;
    else if (df < CLAMP_LO) r = SAT_LO;
    else r = df[31:0];
    return r;
  endfunction

  // Elaboration-time sine via Taylor series; accurate far below one LSB on [0, pi/2].
  function automatic int quarter_sine(input int k, input int n, input int amp);
    real x, term, acc;
    x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(n);
    term = x;
    acc  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    return int'(real'(amp) * acc);
  endfunction

endpackage

// File: rtl/costas_nco_quarter_rom.sv
// Dual-read synchronous quarter-wave sine table, one clock read latency.
module costas_nco_quarter_rom
  import costas_nco_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 11,
  parameter int AMP = 2047
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b
);

  localparam int N = 1 << AW;

  logic [DW-1:0] table_s [N];

  for (genvar g = 0; g < N; g++) begin : g_tab
    localparam int TV = quarter_sine(g, N, AMP);
    assign table_s[g] = DW'(TV);
  end

  // Registered read ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a <= '0;
      data_b <= '0;
    end else begin
      data_a <= table_s[addr_a];
      data_b <= table_s[addr_b];
    end
  end

endmodule

// File: rtl/costas_nco.sv
// Costas-loop carrier NCO: clamped frequency word, phase accumulator, quarter-wave sin/cos.
// Optional phase dither below the lookup bits is enabled by defining COSTAS_NCO_DITHER_EN.
module costas_nco
  import costas_nco_pkg::*;
#(
  parameter int          PHASE_W   = DEF_PHASE_W,
  parameter int          LUT_AW    = DEF_LUT_AW,
  parameter int          OUT_W     = DEF_OUT_W,
  parameter logic [31:0] FREQ_BASE = DEF_FREQ_BASE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [33:0]      frequency_df,
  output logic signed [OUT_W-1:0] sine,
  output logic signed [OUT_W-1:0] cosine,
  output logic                    out_valid
);

  localparam int IDX_W  = LUT_AW - 2;
  localparam int FRAC_W = PHASE_W - LUT_AW;
  localparam int AMP    = (1 << (OUT_W - 1)) - 1;

  logic [31:0]        freq_reg;
  logic [PHASE_W-1:0] phase_acc;
  logic [LUT_AW-1:0]  lookup_s;
  logic [LUT_AW-1:0]  cos_lookup_s;
  logic [IDX_W-1:0]   sin_addr_r, cos_addr_r;
  logic               sin_neg1_r, cos_neg1_r, sin_neg2_r, cos_neg2_r;
  logic [OUT_W-2:0]   sin_data_s, cos_data_s;
  logic signed [OUT_W-1:0] sin_mag_s, cos_mag_s;
  logic [2:0]         vld_cnt_r;

  // Frequency word capture and phase accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_reg  <= '0;
      phase_acc <= '0;
    end else begin
      freq_reg  <= FREQ_BASE + clamp_df(frequency_df);
      phase_acc <= phase_acc + PHASE_W'(freq_reg);
    end
  end

`ifdef COSTAS_NCO_DITHER_EN
  logic [15:0] lfsr_r;

  // Dither LFSR, free-running from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {^(lfsr_r & LFSR_TAPS), lfsr_r[15:1]};
    end
  end

  // Dither only touches the truncated fraction; its carry may bump the lookup phase.
  assign lookup_s = LUT_AW'((phase_acc + PHASE_W'(FRAC_W'(lfsr_r))) >> FRAC_W);
`else
  assign lookup_s = LUT_AW'(phase_acc >> FRAC_W);
`endif

  assign cos_lookup_s = lookup_s + {2'b01, {IDX_W{1'b0}}};

  // Quadrant decode: odd quadrants read the table mirrored, upper half is negated later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_addr_r <= '0;
      cos_addr_r <= '0;
      sin_neg1_r <= 1'b0;
      cos_neg1_r <= 1'b0;
    end else begin
      sin_addr_r <= lookup_s[IDX_W] ? ~lookup_s[IDX_W-1:0] : lookup_s[IDX_W-1:0];
      cos_addr_r <= cos_lookup_s[IDX_W] ? ~cos_lookup_s[IDX_W-1:0] : cos_lookup_s[IDX_W-1:0];
      sin_neg1_r <= lookup_s[LUT_AW-1];
      cos_neg1_r <= cos_lookup_s[LUT_AW-1];
    end
  end

  costas_nco_quarter_rom #(
    .AW  (IDX_W),
    .DW  (OUT_W - 1),
    .AMP (AMP)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_a (sin_addr_r),
    .addr_b (cos_addr_r),
    .data_a (sin_data_s),
    .data_b (cos_data_s)
  );

  assign sin_mag_s = {1'b0, sin_data_s};
  assign cos_mag_s = {1'b0, cos_data_s};

  // Sign alignment with the table read, then signed output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_neg2_r <= 1'b0;
      cos_neg2_r <= 1'b0;
      sine       <= '0;
      cosine     <= '0;
    end else begin
      sin_neg2_r <= sin_neg1_r;
      cos_neg2_r <= cos_neg1_r;
      sine       <= sin_neg2_r ? -sin_mag_s : sin_mag_s;
      cosine     <= cos_neg2_r ? -cos_mag_s : cos_mag_s;
    end
  end

  // Valid counter saturates at 4 once the pipeline is filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_cnt_r <= 3'd0;
    end else if (vld_cnt_r != 3'd4) begin
      vld_cnt_r <= vld_cnt_r + 3'd1;
    end else begin
      vld_cnt_r <= vld_cnt_r;
    end
  end

  assign out_valid = vld_cnt_r[2];

endmodule

// File: doc/costas_nco.md
# costas_nco

Numerically controlled oscillator closing the DPSK Costas carrier loop. Takes the signed 34-bit loop-filter correction `frequency_df`, adds it to a fixed carrier phase increment, and accumulates phase at the 32 MHz system clock. Produces registered sine/cosine samples from a quarter-wave table, which drive the I/Q mixers ahead of the phase detector.

## Interface
- `PHASE_W`, 32: phase accumulator width (bits).
- `LUT_AW`, 10: phase bits used for table lookup (2 quadrant bits + `LUT_AW-2` index bits).
- `OUT_W`, 12: signed sine/cosine output width.
- `FREQ_BASE`, 32'h4000_0000: nominal carrier phase increment (fs/4 = 8 MHz).

Ports:
- `clk`  in  1  FPGA system clock, 32 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `frequency_df`  in  34 signed  loop-filter output, sampled every clock, no strobe.
- `sine`  out  `OUT_W` signed  local carrier, in-phase reference.
- `cosine`  out  `OUT_W` signed  local carrier, quadrature reference.
- `out_valid`  out  1  high once the pipeline holds post-reset data.

## Operation
- Clamp: `frequency_df` is saturated to signed 32-bit range: values above 2^31-1 become 0x7FFF_FFFF, values below -2^31 become 0x8000_0000.
- Frequency word: `freq_reg = FREQ_BASE + clamped`, modulo 2^32. It is registered.
- Accumulator: `phase_acc <= phase_acc + freq_reg`, modulo 2^PHASE_W. Wrap-around is silent.
- Lookup phase: top `LUT_AW` bits of `phase_acc`. Cosine uses the lookup phase + 2^(LUT_AW-2), i.e. +90°.
- Quadrant q = top 2 bits. Index k = next `LUT_AW-2` bits. N = 2^(LUT_AW-2).
- Table: T[k] = round((2^(OUT_W-1)-1)·sin(π/2·(k+0.5)/N)). With defaults, T[0]=6 and T[255]=2047.
- Output mapping by quadrant:
  - q0: +T[k]
  - q1: +T[N-1-k]
  - q2: -T[k]
  - q3: -T[N-1-k]
- Because of the half-sample offset, the output is never 0 and never -2^(OUT_W-1). Negation therefore cannot overflow.
- `out_valid`: a 3-bit saturating counter after reset; goes high when the counter reaches 4.

## Timing
- Reset values: `freq_reg`=0, `phase_acc`=0, all pipeline registers 0, `sine`=0, `cosine`=0, `out_valid`=0.
- Edge 1: `frequency_df` is captured into `freq_reg`.
- Edge 2: the accumulator adds the new `freq_reg`.
- Edge 3: quadrant and address are registered.
- Edge 4: table data is registered.
- Edge 5: sign/mirror is applied and `sine`/`cosine` update.
- Latency from accumulator value to outputs: 3 clocks. Throughput: one sample per clock.
- `out_valid` rises on the 4th rising edge after `rst` deasserts and stays high until the next reset.
- `rst` asserted mid-operation clears everything immediately, including `out_valid`, asynchronously. The accumulator restarts from phase 0.
- `frequency_df` changes every 16 clocks upstream. It is sampled every clock with no strobe, so no hold or handshake is required.

## Configuration
- `COSTAS_NCO_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) is seeded 0xACE1 on reset and advances every clock.
  - Its low `PHASE_W-LUT_AW` bits are added to the `phase_acc` fraction below the lookup bits before truncation. The carry propagates into the lookup phase. `phase_acc` itself is not modified.
- Undefined: plain truncation, and no LFSR logic is present.

## Structure
- Package `costas_nco_pkg`: `PHASE_W`, `LUT_AW`, `OUT_W` defaults, `FREQ_BASE` default, the LFSR seed/taps, and the clamp limits.
- Sub-module `costas_nco_quarter_rom`: dual-read synchronous quarter-wave table (N × (OUT_W-1) unsigned). Contents are generated at elaboration from the T[k] formula. It has one read latency.

## Test plan
- Reset, fs/4 carrier: `rst` high, then released. Check `sine`=`cosine`=0 and `out_valid`=0 during reset. With `frequency_df`=0 and defaults:
  - `out_valid` goes high at edge 4.
  - `sine` repeats 6, 2047, -6, -2047.
  - `cosine` repeats 2047, -6, -2047, 6.
- Clamp high: `FREQ_BASE`=0, `frequency_df`=2^33-1. Check `freq_reg`=0x7FFF_FFFF and `phase_acc` steps by 0x7FFF_FFFF per clock.
- Clamp low and negative offset: `frequency_df`=-2^33 → `freq_reg`=0x8000_0000. `frequency_df`=-5 with default base → `freq_reg`=0x3FFF_FFFB.
- Wrap-around: `FREQ_BASE`=0xC000_0000, df=0. Check `phase_acc` sequence 0, 0xC000_0000, 0x8000_0000, 0x4000_0000, 0 and outputs mirror the fs/4 case reversed.
- Mid-run reset: pulse `rst` for 1 clock while running. Outputs and `out_valid` go 0 asynchronously, and the sequence restarts exactly as in the fs/4 reset case.
- Dither (`COSTAS_NCO_DITHER_EN`): check the first LFSR states after reset start at 0xACE1. With df=0, the outputs match the no-dither fs/4 pattern, since the fraction bits are zero and the dither stays below a table step.
